// File: rtl/mod14_counter_checker.sv
// Scoreboard for a mod-14 up/down counter: predicts the next counter value and
// flags mismatches and out-of-range outputs, with a sticky FAIL state.
module mod14_counter_checker #(
  parameter int unsigned ERR_LIMIT = 8
) (
  input  logic        clock,
  input  logic        rest,
  input  logic        load,
  input  logic        mode,
  input  logic [3:0]  data_in,
  input  logic [3:0]  data_out,
  input  logic        resync,
  output logic [3:0]  expected,
  output logic        mismatch,
  output logic        range_err,
  output logic [7:0]  err_count,
  output logic [15:0] txn_count,
  output logic        fail,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    RESYNC = 2'd1,
    FAIL   = 2'd2
  } state_e;

  localparam logic [7:0] ERR_LIMIT_C = 8'(ERR_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  expected_q, expected_d;
  logic        mismatch_q, mismatch_d;
  logic        range_err_q, range_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [15:0] txn_count_q, txn_count_d;
  logic        fail_q, fail_d;

  logic compare, rangeHit, mismatchHit, errHit, resyncReq;

  always_ff @(posedge clock or posedge rest) begin
    if (rest) begin
      state_q     <= TRACK;
      expected_q  <= 4'd0;
      mismatch_q  <= 1'b0;
      range_err_q <= 1'b0;
      err_count_q <= 8'd0;
      txn_count_q <= 16'd0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      mismatch_q  <= mismatch_d;
      range_err_q <= range_err_d;
      err_count_q <= err_count_d;
      txn_count_q <= txn_count_d;
      fail_q      <= fail_d;
    end
  end

  // An out-of-range value is reported as a range error only, never as both.
  always_comb begin
    if (load)
      expected_d = data_in;
    else if (mode)
      expected_d = (data_out == 4'd13) ? 4'd0 : data_out + 4'd1;
    else
      expected_d = (data_out == 4'd0) ? 4'd13 : data_out - 4'd1;

    compare     = (state_q == TRACK);
    rangeHit    = compare && (data_out > 4'd13);
    mismatchHit = compare && !rangeHit && (data_out != expected_q);
    errHit      = rangeHit || mismatchHit;
    resyncReq   = resync || (load && (data_in > 4'd13));

    range_err_d = rangeHit;
    mismatch_d  = mismatchHit;
    err_count_d = (errHit && (err_count_q != 8'd255)) ? err_count_q + 8'd1 : err_count_q;
    txn_count_d = compare ? txn_count_q + 16'd1 : txn_count_q;

    state_d = state_q;
    case (state_q)
      TRACK: begin
        if (errHit && (err_count_d >= ERR_LIMIT_C))
          state_d = FAIL;
        else if (resyncReq)
          state_d = RESYNC;
      end
      RESYNC:  state_d = resyncReq ? RESYNC : TRACK;
      FAIL:    state_d = FAIL;
      default: state_d = TRACK;
    endcase

    fail_d = fail_q || (state_d == FAIL);
  end

  assign expected  = expected_q;
  assign mismatch  = mismatch_q;
  assign range_err = range_err_q;
  assign err_count = err_count_q;
  assign txn_count = txn_count_q;
  assign fail      = fail_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mod14_counter_checker.sv
// Directed plus randomized bench for mod14_counter_checker, checked against a
// behavioural model of the checker's rules kept in plain integer arithmetic.
module tb_mod14_counter_checker;

  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        rest  = 1'b1;
  logic        load  = 1'b0;
  logic        mode  = 1'b1;
  logic [3:0]  data_in  = 4'd0;
  logic [3:0]  data_out = 4'd0;
  logic        resync = 1'b0;
  logic [3:0]  expected;
  logic        mismatch, range_err, fail;
  logic [7:0]  err_count;
  logic [15:0] txn_count;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mExp is the prediction, cnt the value a healthy counter shows next.
  int mExp, mErr, mTxn, mState, cnt;
  bit mMis, mRng, mFail;

  mod14_counter_checker #(.ERR_LIMIT(LIMIT)) dut (
    .clock(clock), .rest(rest), .load(load), .mode(mode),
    .data_in(data_in), .data_out(data_out), .resync(resync),
    .expected(expected), .mismatch(mismatch), .range_err(range_err),
    .err_count(err_count), .txn_count(txn_count), .fail(fail), .state(state)
  );

  always #5 clock = ~clock;

  function automatic int nextValue(input bit ld, input bit md, input int din, input int c);
    if (ld) return din;
    if (md) return (c == 13) ? 0 : (c + 1) % 16;
    return (c == 0) ? 13 : c - 1;
  endfunction

  task automatic modelReset();
    mExp = 0; mErr = 0; mTxn = 0; mState = 0; cnt = 0;
    mMis = 0; mRng = 0; mFail = 0;
  endtask

  task automatic modelStep(input bit ld, input bit md, input int din, input int dout, input bit rs);
    bit illegal;
    illegal = ld && (din > 13);
    mMis = 0;
    mRng = 0;
    if (mState == 0) begin
      mTxn = (mTxn + 1) % 65536;
      if (dout > 13) mRng = 1;
      else if (dout != mExp) mMis = 1;
      if ((mRng || mMis) && mErr < 255) mErr++;
      if ((mRng || mMis) && mErr >= LIMIT) mState = 2;
      else if (rs || illegal) mState = 1;
    end else if (mState == 1) begin
      mState = (rs || illegal) ? 1 : 0;
    end
    mExp  = nextValue(ld, md, din, dout);
    cnt   = mExp;
    mFail = (mState == 2);
  endtask

  task automatic check1(input string tag, input int got, input int want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".expected"},  int'(expected),  mExp);
    check1({tag, ".mismatch"},  int'(mismatch),  int'(mMis));
    check1({tag, ".range_err"}, int'(range_err), int'(mRng));
    check1({tag, ".err_count"}, int'(err_count), mErr);
    check1({tag, ".txn_count"}, int'(txn_count), mTxn);
    check1({tag, ".fail"},      int'(fail),      int'(mFail));
    check1({tag, ".state"},     int'(state),     mState);
  endtask

  task automatic applyStimulus(input string tag, input bit ld, input bit md, input int din,
                               input int dout, input bit rs);
    load = ld; mode = md; data_in = 4'(din); data_out = 4'(dout); resync = rs;
    @(posedge clock);
    modelStep(ld, md, din, dout, rs);
    #1 checkOutput(tag);
  endtask

  // Reset is raised away from any edge and checked before the next edge arrives.
  task automatic doReset(input string tag);
    #2 rest = 1'b1;
    #1 modelReset();
    checkOutput(tag);
    @(negedge clock);
    rest = 1'b0;
  endtask

  initial begin
    modelReset();
    #1 checkOutput("por");
    @(negedge clock);
    rest = 1'b0;

    for (int i = 0; i < 16; i++) applyStimulus("upwrap", 0, 1, 0, cnt, 0);
    check1("upwrap.txn16", int'(txn_count), 16);

    applyStimulus("load9", 1, 1, 9, cnt, 0);
    check1("load9.exp", int'(expected), 9);
    applyStimulus("load9.next", 0, 1, 0, cnt, 0);
    check1("load9.exp10", int'(expected), 10);

    applyStimulus("load0", 1, 0, 0, cnt, 0);
    applyStimulus("down13", 0, 0, 0, cnt, 0);
    check1("down.exp13", int'(expected), 13);
    applyStimulus("down12", 0, 0, 0, cnt, 0);
    check1("down.exp12", int'(expected), 12);

    applyStimulus("illegal14", 1, 1, 14, cnt, 0);
    check1("illegal.state", int'(state), 1);
    applyStimulus("inresync", 0, 1, 0, 3, 0);
    applyStimulus("backtrack", 0, 1, 0, cnt, 0);
    applyStimulus("range15", 0, 1, 0, 15, 0);
    check1("range.pulse", int'(range_err), 1);
    applyStimulus("range.after", 0, 1, 0, cnt, 0);

    doReset("rst1");
    applyStimulus("pre4a", 1, 1, 3, cnt, 0);
    applyStimulus("pre4b", 0, 1, 0, cnt, 0);
    check1("pre4.exp", int'(expected), 4);
    applyStimulus("force5", 0, 1, 0, 5, 0);
    check1("force5.mis", int'(mismatch), 1);
    applyStimulus("force5.after", 0, 1, 0, cnt, 0);
    check1("force5.err", int'(err_count), 1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus("forceN", 0, 1, 0, (mExp + 1) % 14, 0);
      applyStimulus("forceN.after", 0, 1, 0, cnt, 0);
    end
    check1("limit.fail", int'(fail), 1);
    check1("limit.state", int'(state), 2);
    applyStimulus("fail.resync", 0, 1, 0, cnt, 1);
    applyStimulus("fail.frozen", 0, 1, 0, 7, 0);
    check1("fail.stay", int'(state), 2);

    doReset("asyncrst");

    for (int i = 0; i < 400; i++) begin
      bit ld, md, rs, bad;
      int din, dout;
      ld   = ($urandom_range(0, 7) == 0);
      md   = $urandom_range(0, 1);
      din  = $urandom_range(0, 15);
      rs   = ($urandom_range(0, 15) == 0);
      bad  = ($urandom_range(0, 19) == 0);
      dout = bad ? $urandom_range(0, 15) : cnt;
      applyStimulus("rand", ld, md, din, dout, rs);
      if (i % 100 == 99) doReset("rand.rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
